multiport_ram: RTL and testbench
================================

MULTIPORT_RAM -- requirements
Module: multiport_ram

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels, 1..8.
REQ-002 SHALL have parameter WIDTH, default 32: data word width in bits.
REQ-003 SHALL have parameter DEPTH, default 16384: words of storage, power of two.
REQ-004 SHALL have parameter LAT, default 1: wait cycles before ACCESS, 1..15.
REQ-005 SHALL have parameter BAD, default 32'hBAD1BAD1 (WIDTH bits): load value when not in ACCESS.
REQ-006 SHALL have port CLK  input  1: sole clock, rising edge.
REQ-007 SHALL have port nRST  input  1: reset, asynchronous, active-low.
REQ-008 SHALL have port ramREN  input  NCH: per-channel read request.
REQ-009 SHALL have port ramWEN  input  NCH: per-channel write request.
REQ-010 SHALL have port ramaddr  input  NCH x 32: per-channel byte address; word index = bits [log2(DEPTH)+1:2].
REQ-011 SHALL have port ramstore  input  NCH x WIDTH: per-channel write data.
REQ-012 SHALL have port ramload  output  NCH x WIDTH: per-channel read data.
REQ-013 SHALL have port ramstate  output  NCH x ramstate_t: per-channel FREE/BUSY/ACCESS/ERROR.

Function
REQ-014 Channel state SHALL be ERROR when ren=1 and wen=1; SHALL be FREE when ren=0 and wen=0; the channel then SHALL NOT be granted.
REQ-015 Arbiter SHALL be round-robin: when idle, it SHALL grant the first requesting channel at or after the priority pointer; pointer SHALL move to served channel+1 (mod NCH) on its ACCESS.
REQ-016 On grant, the block SHALL latch the channel's addr and {ren,wen} and clear the wait counter; the counter SHALL increment each following cycle.
REQ-017 Granted channel SHALL show BUSY while count<LAT and ACCESS for exactly one cycle, when count==LAT; ACCESS is first seen LAT cycles after the grant cycle.
REQ-018 Non-granted requesting channels SHALL show BUSY.
REQ-019 During ACCESS, a read SHALL drive ramload of the granted channel with the word at the latched address; all other ramload SHALL equal BAD.
REQ-020 During ACCESS, a write SHALL store ramstore at the closing clock edge; no write SHALL occur in any other cycle.
REQ-021 If the granted channel changes addr or {ren,wen} before ACCESS, the transaction SHALL abort; the grant SHALL be released with no write and the pointer unchanged; arbitration SHALL restart next cycle.
REQ-022 After ACCESS, the grant SHALL release; a channel still requesting SHALL be treated as a new transaction subject to arbitration.
REQ-023 Same-address requests on different channels SHALL be serialised in grant order; a read granted after a write SHALL return the written data.
REQ-024 One transaction SHALL be in flight at a time; throughput is one access per LAT+1 cycles.

Reset
REQ-025 While nRST=0: grant cleared, counter 0, pointer 0, all ramload=BAD, all ramstate=FREE, no write.
REQ-026 Reset asserted mid-transaction SHALL abort it without write; memory contents SHALL be retained.
REQ-027 First grant SHALL be possible in the first clock edge after nRST rises.

Configuration
REQ-028 Macro MULTIPORT_RAM_BYTE_EN: when defined, SHALL add input ramben (NCH x WIDTH/8); on write ACCESS only bytes with ramben=1 SHALL update.
REQ-029 Without MULTIPORT_RAM_BYTE_EN, port ramben SHALL be absent and writes SHALL update the full word.

Verification
REQ-030 LAT=1, ch0 write addr 0x40 data 0xDEADBEEF, then read 0x40 -> BUSY 1 cycle, ACCESS 1 cycle each; read load=0xDEADBEEF.
REQ-031 LAT=3, ch0 and ch1 read simultaneously, pointer 0 -> ch0 ACCESS at cycle 3, ch1 ACCESS at cycle 7; ch1 BUSY throughout cycles 0-6.
REQ-032 ch0 ren=1,wen=1 -> ch0 ERROR, never granted; ch1 read proceeds normally.
REQ-033 LAT=3, ch0 write 0x80, addr changed to 0x84 at cycle 1 -> abort, 0x80 unchanged, new transaction ACCESS at cycle 4.
REQ-034 nRST pulsed low during write BUSY -> all states FREE, loads BAD; subsequent read of that address returns old data.
REQ-035 With MULTIPORT_RAM_BYTE_EN, word 0x11223344, write 0xAABBCCDD with ramben=0101 -> read 0x11BB33DD.

Source files
------------

// File: rtl/multiport_ram.sv
`default_nettype none
// ============================================================================
// Module   : multiport_ram
// Purpose  : Single-port word memory shared by NCH requester channels.
//            A round-robin arbiter serves one transaction at a time. A granted
//            transaction waits LAT cycles, then gets exactly one ACCESS cycle.
//            Reads return data combinationally during ACCESS. Writes commit at
//            the clock edge that closes ACCESS.
// Ports    : CLK       - clock, rising edge
//            nRST      - asynchronous active-low reset
//            ramREN    - per-channel read request           [NCH]
//            ramWEN    - per-channel write request          [NCH]
//            ramaddr   - per-channel byte address           [NCH x 32]
//            ramstore  - per-channel write data             [NCH x WIDTH]
//            ramben    - per-channel byte enables           [NCH x WIDTH/8]
//                        (only when MULTIPORT_RAM_BYTE_EN is defined)
//            ramload   - per-channel read data, BAD unless serving a read
//            ramstate  - per-channel 2-bit state:
//                        0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// Options  : `define MULTIPORT_RAM_BYTE_EN adds ramben. Only the enabled bytes
//            of a write are updated. Without the macro, a write replaces the
//            full word.
// Revision : 1.0 - initial release
// ============================================================================
module multiport_ram #(
    parameter int               NCH   = 2,
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 16384,
    parameter int               LAT   = 1,
    parameter logic [WIDTH-1:0] BAD   = WIDTH'(32'hBAD1BAD1)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NCH-1:0]           ramREN,
    input  logic [NCH-1:0]           ramWEN,
    input  logic [NCH*32-1:0]        ramaddr,
    input  logic [NCH*WIDTH-1:0]     ramstore,
`ifdef MULTIPORT_RAM_BYTE_EN
    input  logic [NCH*(WIDTH/8)-1:0] ramben,
`endif
    output logic [NCH*WIDTH-1:0]     ramload,
    output logic [NCH*2-1:0]         ramstate
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef MULTIPORT_RAM_BYTE_EN
    localparam int NB = WIDTH / 8;
`endif

    localparam logic [3:0] c_lat       = 4'(LAT);
    localparam logic [1:0] c_st_free   = 2'd0;
    localparam logic [1:0] c_st_busy   = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_error  = 2'd3;
    localparam logic [1:0] c_rw_read   = 2'b10;
    localparam logic [1:0] c_rw_write  = 2'b01;

    // ------------------------------------------------------------------------
    // Per-channel views of the flattened ports
    // ------------------------------------------------------------------------
    logic [31:0]      w_addr  [NCH];
    logic [WIDTH-1:0] w_store [NCH];
    logic [1:0]       w_rw    [NCH];
    logic [NCH-1:0]   w_req;
`ifdef MULTIPORT_RAM_BYTE_EN
    logic [NB-1:0]    w_ben   [NCH];
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign w_addr[i]  = ramaddr[i*32 +: 32];
        assign w_store[i] = ramstore[i*WIDTH +: WIDTH];
        assign w_rw[i]    = {ramREN[i], ramWEN[i]};
        // Only a pure read or a pure write is a valid request.
        assign w_req[i]   = ramREN[i] ^ ramWEN[i];
`ifdef MULTIPORT_RAM_BYTE_EN
        assign w_ben[i]   = ramben[i*NB +: NB];
`endif
    end

    // ------------------------------------------------------------------------
    // Transaction registers
    // ------------------------------------------------------------------------
    logic             r_active;   // a grant is held
    logic [IW-1:0]    r_gnt;      // granted channel
    logic [31:0]      r_addr;     // address latched at grant
    logic [1:0]       r_rw;       // {ren,wen} latched at grant
    logic [3:0]       r_cnt;      // wait count of the held grant
    logic [IW-1:0]    r_ptr;      // round-robin priority pointer
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_abort;
    logic             w_held;
    logic             w_access;
    logic             w_new_valid;
    logic [IW-1:0]    w_new_idx;
    logic [IW-1:0]    w_scan;
    logic [AW-1:0]    w_widx;

    assign w_widx = r_addr[AW+1:2];

    // A held grant is dropped as soon as its owner changes the address or the
    // request kind. In that same cycle, the arbiter counts as idle and can grant again.
    assign w_abort  = r_active &&
                      ((w_addr[r_gnt] != r_addr) || (w_rw[r_gnt] != r_rw));
    assign w_held   = r_active && !w_abort;
    assign w_access = w_held && (r_cnt == c_lat);

    // The first requester at or after the pointer wins. The scan runs from the
    // far end downward, so the closest requester is assigned last.
    always_comb begin
        w_new_valid = 1'b0;
        w_new_idx   = '0;
        w_scan      = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_scan = IW'((int'(r_ptr) + k) % NCH);
            if (w_req[w_scan]) begin
                w_new_valid = 1'b1;
                w_new_idx   = w_scan;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant / counter / pointer control
    // The grant decision is combinational in the idle cycle. That cycle acts
    // as count 0, so the register is loaded with 1 at the grant edge. ACCESS
    // then falls exactly LAT cycles after the grant cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_active <= 1'b0;
            r_gnt    <= '0;
            r_addr   <= '0;
            r_rw     <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
        end else if (w_access) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_ptr    <= (r_gnt == IW'(NCH - 1)) ? '0 : r_gnt + IW'(1);
        end else if (w_held) begin
            r_cnt    <= r_cnt + 4'd1;
        end else if (w_new_valid) begin
            r_active <= 1'b1;
            r_gnt    <= w_new_idx;
            r_addr   <= w_addr[w_new_idx];
            r_rw     <= w_rw[w_new_idx];
            r_cnt    <= 4'd1;
        end else begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: no reset, so contents survive nRST. The async reset clears
    // r_active at once, so no write can happen while nRST is low.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (w_access && (r_rw == c_rw_write)) begin
`ifdef MULTIPORT_RAM_BYTE_EN
            for (int b = 0; b < NB; b++) begin
                if (w_ben[r_gnt][b]) begin
                    r_mem[w_widx][b*8 +: 8] <= w_store[r_gnt][b*8 +: 8];
                end
            end
`else
            r_mem[w_widx] <= w_store[r_gnt];
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel status and read data
    // ------------------------------------------------------------------------
    always_comb begin
        ramstate = '0;
        ramload  = {NCH{BAD}};
        for (int i = 0; i < NCH; i++) begin
            if (!nRST || (w_rw[i] == 2'b00)) begin
                ramstate[i*2 +: 2] = c_st_free;
            end else if (w_rw[i] == 2'b11) begin
                ramstate[i*2 +: 2] = c_st_error;
            end else if (w_access && (r_gnt == IW'(i))) begin
                ramstate[i*2 +: 2] = c_st_access;
            end else begin
                ramstate[i*2 +: 2] = c_st_busy;
            end
        end
        if (w_access && (r_rw == c_rw_read)) begin
            ramload[r_gnt*WIDTH +: WIDTH] = r_mem[w_widx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiport_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_ram
// Purpose  : Self-checking bench for multiport_ram. Runs directed scenarios
//            (LAT=1 and LAT=3 instances) followed by randomized traffic that
//            is compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_ram;

    localparam int          NA   = 3;
    localparam int          LATA = 3;
    localparam int          NBB  = 2;
    localparam logic [31:0] BAD  = 32'hBAD1BAD1;

    localparam logic [1:0] c_st_free   = 2'd0;
    localparam logic [1:0] c_st_busy   = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_error  = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic [NA-1:0]    a_ren, a_wen;
    logic [NA*32-1:0] a_addr, a_store, a_load;
    logic [NA*2-1:0]  a_state;
    logic [NBB-1:0]    b_ren, b_wen;
    logic [NBB*32-1:0] b_addr, b_store, b_load;
    logic [NBB*2-1:0]  b_state;
`ifdef MULTIPORT_RAM_BYTE_EN
    logic [NA*4-1:0]  a_ben;
    logic [NBB*4-1:0] b_ben;
`endif

    multiport_ram #(.NCH(NA), .WIDTH(32), .DEPTH(256), .LAT(LATA), .BAD(BAD)) dut_a (
        .CLK(CLK), .nRST(nRST), .ramREN(a_ren), .ramWEN(a_wen),
        .ramaddr(a_addr), .ramstore(a_store),
`ifdef MULTIPORT_RAM_BYTE_EN
        .ramben(a_ben),
`endif
        .ramload(a_load), .ramstate(a_state)
    );

    multiport_ram #(.NCH(NBB), .WIDTH(32), .DEPTH(256), .LAT(1), .BAD(BAD)) dut_b (
        .CLK(CLK), .nRST(nRST), .ramREN(b_ren), .ramWEN(b_wen),
        .ramaddr(b_addr), .ramstore(b_store),
`ifdef MULTIPORT_RAM_BYTE_EN
        .ramben(b_ben),
`endif
        .ramload(b_load), .ramstate(b_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] a_st(input int ch);
        return a_state[ch*2 +: 2];
    endfunction

    function automatic logic [31:0] a_ld(input int ch);
        return a_load[ch*32 +: 32];
    endfunction

    // One isolated transaction on DUT A. Ends with the request dropped.
    task automatic a_txn(input int ch, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] load);
        bit seen;
        @(posedge CLK); #1;
        a_ren[ch] = !wr;
        a_wen[ch] = wr;
        a_addr[ch*32 +: 32]  = addr;
        a_store[ch*32 +: 32] = data;
        seen = 1'b0;
        load = 'x;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge CLK);
            if (a_st(ch) == c_st_access) begin
                seen = 1'b1;
                load = a_ld(ch);
            end
        end
        check("txn_access_seen", 96'(seen), 96'(1));
        @(posedge CLK); #1;
        a_ren[ch] = 1'b0;
        a_wen[ch] = 1'b0;
    endtask

    // Reference-model state for the random phase
    logic [31:0] m_mem [logic [31:0]];
    bit          act      [NA];
    bit          drv_err  [NA];
    int          err_left [NA];
    bit          m_busy;
    int          m_owner, m_left, m_ptr, r, c;
    logic [31:0] ld, ma;
    logic [1:0]  exp_st;

    initial begin
        a_ren = '0; a_wen = '0; a_addr = '0; a_store = '0;
        b_ren = '0; b_wen = '0; b_addr = '0; b_store = '0;
`ifdef MULTIPORT_RAM_BYTE_EN
        a_ben = '1; b_ben = '1;
`endif
        // ---------------- reset state, with requests asserted ----------------
        a_ren = '1;
        b_wen = '1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_state_a", 96'(a_state), 96'(0));
        check("rst_load_a", 96'(a_load), {3{BAD}});
        check("rst_state_b", 96'(b_state), 96'(0));
        check("rst_load_b", 96'(b_load), 96'({2{BAD}}));
        a_ren = '0;
        b_wen = '0;
        nRST = 1'b1;

        // ---------------- LAT=1: write 0x40 then read it ----------------
        @(posedge CLK); #1;
        b_wen[0] = 1'b1; b_addr[31:0] = 32'h40; b_store[31:0] = 32'hDEADBEEF;
        @(negedge CLK); check("l1_wr_c0_busy", 96'(b_state[1:0]), 96'(c_st_busy));
        @(posedge CLK); #1;
        @(negedge CLK); check("l1_wr_c1_access", 96'(b_state[1:0]), 96'(c_st_access));
        @(posedge CLK); #1;
        b_wen[0] = 1'b0; b_ren[0] = 1'b1;
        @(negedge CLK); check("l1_rd_c0_busy", 96'(b_state[1:0]), 96'(c_st_busy));
        check("l1_rd_c0_load", 96'(b_load[31:0]), 96'(BAD));
        @(posedge CLK); #1;
        @(negedge CLK); check("l1_rd_c1_access", 96'(b_state[1:0]), 96'(c_st_access));
        check("l1_rd_load", 96'(b_load[31:0]), 96'(32'hDEADBEEF));
        @(posedge CLK); #1;
        b_ren[0] = 1'b0;
        @(negedge CLK); check("l1_free", 96'(b_state[1:0]), 96'(c_st_free));

        // ---------------- preload DUT A ----------------
        a_txn(0, 1'b1, 32'h10, 32'h11110010, ld);
        a_txn(0, 1'b1, 32'h20, 32'h22220020, ld);
        a_txn(0, 1'b1, 32'h80, 32'h80808080, ld);
        a_txn(0, 1'b1, 32'h84, 32'h84848484, ld);

        // ---- two simultaneous reads, requests present as reset releases ----
        @(negedge CLK); nRST = 1'b0;
        for (int cy = 0; cy < 8; cy++) begin
            @(posedge CLK); #1;
            if (cy == 0) begin
                a_ren[0] = 1'b1; a_addr[31:0]  = 32'h10;
                a_ren[1] = 1'b1; a_addr[63:32] = 32'h20;
                #1 nRST = 1'b1;
            end
            if (cy == 4) a_ren[0] = 1'b0;
            @(negedge CLK);
            check("rr_ch0_state", 96'(a_st(0)),
                  96'((cy < 3) ? c_st_busy : (cy == 3) ? c_st_access : c_st_free));
            check("rr_ch1_state", 96'(a_st(1)),
                  96'((cy < 7) ? c_st_busy : c_st_access));
            if (cy == 3) begin
                check("rr_ch0_load", 96'(a_ld(0)), 96'(32'h11110010));
                check("rr_ch1_load_bad", 96'(a_ld(1)), 96'(BAD));
            end
            if (cy == 7) check("rr_ch1_load", 96'(a_ld(1)), 96'(32'h22220020));
        end
        @(posedge CLK); #1; a_ren[1] = 1'b0;

        // ---------------- ERROR channel never granted ----------------
        for (int cy = 0; cy < 6; cy++) begin
            @(posedge CLK); #1;
            if (cy == 0) begin
                a_ren[0] = 1'b1; a_wen[0] = 1'b1;
                a_ren[1] = 1'b1; a_addr[63:32] = 32'h20;
            end
            if (cy == 4) a_ren[1] = 1'b0;
            @(negedge CLK);
            check("err_ch0_state", 96'(a_st(0)), 96'(c_st_error));
            check("err_ch1_state", 96'(a_st(1)),
                  96'((cy < 3) ? c_st_busy : (cy == 3) ? c_st_access : c_st_free));
            if (cy == 3) begin
                check("err_ch1_load", 96'(a_ld(1)), 96'(32'h22220020));
                check("err_ch0_load_bad", 96'(a_ld(0)), 96'(BAD));
            end
        end
        @(posedge CLK); #1; a_ren[0] = 1'b0; a_wen[0] = 1'b0;

        // ---------------- abort on address change ----------------
        for (int cy = 0; cy < 7; cy++) begin
            @(posedge CLK); #1;
            if (cy == 0) begin
                a_wen[0] = 1'b1; a_addr[31:0] = 32'h80; a_store[31:0] = 32'hCAFE0080;
            end
            if (cy == 1) a_addr[31:0] = 32'h84;
            if (cy == 5) a_wen[0] = 1'b0;
            @(negedge CLK);
            check("abort_ch0_state", 96'(a_st(0)),
                  96'((cy < 4) ? c_st_busy : (cy == 4) ? c_st_access : c_st_free));
        end
        a_txn(0, 1'b0, 32'h80, 32'h0, ld);
        check("abort_old_addr_kept", 96'(ld), 96'(32'h80808080));
        a_txn(0, 1'b0, 32'h84, 32'h0, ld);
        check("abort_new_addr_written", 96'(ld), 96'(32'hCAFE0080));

        // ---------------- reset during a write in BUSY ----------------
        @(posedge CLK); #1;
        a_wen[2] = 1'b1; a_addr[95:64] = 32'h10; a_store[95:64] = 32'hDEAD0010;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("mid_rst_busy", 96'(a_st(2)), 96'(c_st_busy));
        nRST = 1'b0;
        #1;
        check("mid_rst_state", 96'(a_state), 96'(0));
        check("mid_rst_load", 96'(a_load), {3{BAD}});
        @(posedge CLK); #1;
        a_wen[2] = 1'b0;
        @(negedge CLK); nRST = 1'b1;
        a_txn(2, 1'b0, 32'h10, 32'h0, ld);
        check("mid_rst_no_write", 96'(ld), 96'(32'h11110010));

`ifdef MULTIPORT_RAM_BYTE_EN
        // ---------------- byte enables ----------------
        a_txn(0, 1'b1, 32'h30, 32'h11223344, ld);
        a_ben[3:0] = 4'b0101;
        a_txn(0, 1'b1, 32'h30, 32'hAABBCCDD, ld);
        a_ben = '1;
        a_txn(0, 1'b0, 32'h30, 32'h0, ld);
        check("byte_en_merge", 96'(ld), 96'(32'h11BB33DD));
`endif

        // ---------------- randomized traffic vs reference model ----------------
        @(negedge CLK); nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK); nRST = 1'b1;
        m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_left = 0;
        for (int ch = 0; ch < NA; ch++) begin
            act[ch] = 1'b0; drv_err[ch] = 1'b0; err_left[ch] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge CLK); #1;
            for (int ch = 0; ch < NA; ch++) begin
                if (!act[ch]) begin
                    drv_err[ch] = 1'b0;
                    if (err_left[ch] > 0) begin
                        err_left[ch]--;
                        drv_err[ch] = 1'b1;
                        a_ren[ch] = 1'b1; a_wen[ch] = 1'b1;
                    end else begin
                        r = int'($urandom_range(0, 9));
                        if (r < 5) begin
                            act[ch] = 1'b1;
                            a_wen[ch] = 1'($urandom_range(0, 1));
                            a_ren[ch] = !a_wen[ch];
                            a_addr[ch*32 +: 32]  = 32'h100 + 32'(4 * $urandom_range(0, 7));
                            a_store[ch*32 +: 32] = $urandom;
                        end else if (r == 5) begin
                            drv_err[ch]  = 1'b1;
                            err_left[ch] = int'($urandom_range(0, 2));
                            a_ren[ch] = 1'b1; a_wen[ch] = 1'b1;
                        end else begin
                            a_ren[ch] = 1'b0; a_wen[ch] = 1'b0;
                        end
                    end
                end
            end
            @(negedge CLK);
            if (!m_busy) begin
                for (int k = 0; k < NA; k++) begin
                    c = (m_ptr + k) % NA;
                    if (!m_busy && act[c]) begin
                        m_busy = 1'b1; m_owner = c; m_left = LATA;
                    end
                end
            end
            for (int ch = 0; ch < NA; ch++) begin
                if (drv_err[ch])      exp_st = c_st_error;
                else if (!act[ch])    exp_st = c_st_free;
                else if (m_busy && m_owner == ch && m_left == 0) exp_st = c_st_access;
                else                  exp_st = c_st_busy;
                check("rnd_state", 96'(a_st(ch)), 96'(exp_st));
            end
            if (m_busy && m_left == 0) begin
                ma = a_addr[m_owner*32 +: 32];
                for (int ch = 0; ch < NA; ch++) begin
                    if (ch == m_owner && !a_wen[ch]) begin
                        if (m_mem.exists(ma)) check("rnd_read", 96'(a_ld(ch)), 96'(m_mem[ma]));
                    end else begin
                        check("rnd_load_bad", 96'(a_ld(ch)), 96'(BAD));
                    end
                end
                if (a_wen[m_owner]) m_mem[ma] = a_store[m_owner*32 +: 32];
                act[m_owner] = 1'b0;
                m_busy = 1'b0;
                m_ptr = (m_owner + 1) % NA;
            end else begin
                if (m_busy) m_left--;
                check("rnd_idle_load", 96'(a_load), {3{BAD}});
            end
        end
        @(posedge CLK); #1;
        a_ren = '0; a_wen = '0;
        @(negedge CLK);
        check("final_free", 96'(a_state), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
